// File: rtl/defs.sv
// rtl/defs.sv - shared row count and row/address types for sort_mem
package defs;

  localparam int NUM_ROWS = 4;
  localparam int ROW_W    = $clog2(NUM_ROWS);

  // One spare address bit so that out-of-range sorter addresses are representable.
  typedef logic [ROW_W:0] t_addr;
  typedef logic [7:0]     t_data;

endpackage

// File: rtl/sort_mem.sv
// rtl/sort_mem.sv - row buffer that loads a stream, lends itself to an external sorter, then dumps
module sort_mem
  import defs::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  cmd_go,
  output logic  busy,
  input  logic  in_valid,
  output logic  in_ready,
  input  t_data in_data,
  output logic  out_valid,
  input  logic  out_ready,
  output t_data out_data,
  output logic  out_last,
  output logic  srt_start,
  input  logic  srt_done,
  input  t_addr srt_rd_addr,
  output t_data srt_rd_data,
  input  logic  srt_wr_en,
  input  t_addr srt_wr_addr,
  input  t_data srt_wr_data
);

  typedef enum logic [2:0] {IDLE, LOAD, KICK, SORT, DUMP} state_t;

  localparam t_addr LAST_ROW  = t_addr'(NUM_ROWS - 1);
  localparam t_addr ROW_LIMIT = t_addr'(NUM_ROWS);

  state_t state, state_nx;
  t_addr  load_ptr, dump_ptr;
  t_data  mem [NUM_ROWS];

  logic             load_hs, dump_hs, sort_wr;
  logic             mem_we;
  logic [ROW_W-1:0] mem_wrow;
  t_data            mem_wdata;

  function automatic logic in_range(input t_addr a);
    return a < ROW_LIMIT;
  endfunction

  assign load_hs = (state == LOAD) && in_valid;
  assign dump_hs = (state == DUMP) && out_ready;
  assign sort_wr = (state == SORT) && srt_wr_en;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (cmd_go) state_nx = LOAD;
      LOAD: if (load_hs && load_ptr == LAST_ROW) state_nx = KICK;
      KICK: state_nx = SORT;
      SORT: if (srt_done) state_nx = DUMP;
      DUMP: if (dump_hs && dump_ptr == LAST_ROW) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      load_ptr <= '0;
      dump_ptr <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && state_nx == LOAD)
        load_ptr <= '0;
      else if (load_hs)
        load_ptr <= load_ptr + 1'b1;
      if (state == SORT && state_nx == DUMP)
        dump_ptr <= '0;
      else if (dump_hs)
        dump_ptr <= dump_ptr + 1'b1;
    end
  end

  // Loader and sorter never share a state, so a plain priority mux gives the single write port.
  always_comb begin
    mem_we    = 1'b0;
    mem_wrow  = load_ptr[ROW_W-1:0];
    mem_wdata = in_data;
    if (load_hs) begin
      mem_we = in_range(load_ptr);
    end else if (sort_wr) begin
      mem_we    = in_range(srt_wr_addr);
      mem_wrow  = srt_wr_addr[ROW_W-1:0];
      mem_wdata = srt_wr_data;
    end
  end

  // Contents are deliberately left unreset; only writes are held off during reset.
  always_ff @(posedge clk) begin
    if (mem_we && !rst)
      mem[mem_wrow] <= mem_wdata;
  end

  assign busy      = (state != IDLE);
  assign in_ready  = (state == LOAD);
  assign srt_start = (state == KICK);
  assign out_valid = (state == DUMP);
  assign out_last  = out_valid && (dump_ptr == LAST_ROW);

  // Reads see the array before this cycle's write lands, giving read-old-value behaviour.
  always_comb begin
    out_data = '0;
    if (out_valid && in_range(dump_ptr))
      out_data = mem[dump_ptr[ROW_W-1:0]];
  end

  always_comb begin
    srt_rd_data = '0;
    if (state == SORT && in_range(srt_rd_addr))
      srt_rd_data = mem[srt_rd_addr[ROW_W-1:0]];
  end

endmodule

// File: tb/tb_sort_mem.sv
// tb/tb_sort_mem.sv - self-checking bench for sort_mem with a behavioural sorter attached
module tb_sort_mem;
  import defs::*;

  typedef t_data [NUM_ROWS-1:0] job_t;
  typedef struct packed {
    job_t in_w;
    job_t exp_w;
  } vec_t;

  logic  clk = 1'b0;
  logic  rst, cmd_go, busy, in_valid, in_ready, out_valid, out_ready, out_last;
  logic  srt_start, srt_done, srt_wr_en;
  t_data in_data, out_data, srt_rd_data, srt_wr_data;
  t_addr srt_rd_addr, srt_wr_addr;

  int n_checks = 0;
  int n_fail   = 0;

  sort_mem dut (
    .clk(clk), .rst(rst), .cmd_go(cmd_go), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .srt_start(srt_start), .srt_done(srt_done),
    .srt_rd_addr(srt_rd_addr), .srt_rd_data(srt_rd_data),
    .srt_wr_en(srt_wr_en), .srt_wr_addr(srt_wr_addr), .srt_wr_data(srt_wr_data)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic job_t mk(input int a, input int b, input int c, input int d);
    job_t j;
    j[0] = t_data'(a); j[1] = t_data'(b); j[2] = t_data'(c); j[3] = t_data'(d);
    return j;
  endfunction

  function automatic job_t ref_sort(input job_t w);
    t_data q[$];
    job_t  e;
    for (int r = 0; r < NUM_ROWS; r++) q.push_back(w[r]);
    q.sort();
    for (int r = 0; r < NUM_ROWS; r++) e[r] = q[r];
    return e;
  endfunction

  task automatic start_job();
    #1;
    check("idle_busy", busy, 0);
    cmd_go = 1'b1;
    tick();
    cmd_go = 1'b0;
    #1;
    check("load_in_ready", in_ready, 1);
    check("load_busy", busy, 1);
  endtask

  task automatic load_words(input job_t w, input bit stall);
    int i = 0;
    int guard = 0;
    while (i < NUM_ROWS && guard < 100) begin
      in_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = in_valid ? w[i] : t_data'($urandom);
      #1;
      if (in_valid && in_ready) i++;
      tick();
      guard++;
    end
    in_valid = 1'b0;
    if (i < NUM_ROWS) check("load_timeout", i, NUM_ROWS);
    #1;
    check("kick_start", srt_start, 1);
    check("kick_in_ready", in_ready, 0);
    tick();
    #1;
    check("kick_one_cycle", srt_start, 0);
  endtask

  // Behavioural sorter: reads every row, selection-sorts, writes back.
  task automatic sorter(input bit done_with_write);
    t_data a [NUM_ROWS];
    t_data tmp;
    int    m;
    for (int r = 0; r < NUM_ROWS; r++) begin
      srt_rd_addr = t_addr'(r);
      #1;
      a[r] = srt_rd_data;
    end
    for (int r = 0; r < NUM_ROWS - 1; r++) begin
      m = r;
      for (int s = r + 1; s < NUM_ROWS; s++)
        if (a[s] < a[m]) m = s;
      tmp = a[r]; a[r] = a[m]; a[m] = tmp;
    end
    for (int r = 0; r < NUM_ROWS; r++) begin
      srt_wr_en   = 1'b1;
      srt_wr_addr = t_addr'(r);
      srt_wr_data = a[r];
      srt_done    = done_with_write && (r == NUM_ROWS - 1);
      tick();
    end
    srt_wr_en = 1'b0;
    srt_done  = 1'b0;
    if (!done_with_write) begin
      #1;
      check("sort_waits_done", out_valid, 0);
      srt_done = 1'b1;
      tick();
      srt_done = 1'b0;
    end
  endtask

  task automatic dump(input job_t exp, input int mode);
    int    k = 0;
    int    cyc = 0;
    t_data held = '0;
    bit    stalled = 1'b0;
    while (k < NUM_ROWS && cyc < 100) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready = ($urandom_range(0, 1) == 1);
      endcase
      #1;
      check("dump_valid", out_valid, 1);
      check("dump_data", out_data, exp[k]);
      check("dump_last", out_last, k == NUM_ROWS - 1);
      if (stalled) check("dump_hold", out_data, held);
      held    = out_data;
      stalled = !out_ready;
      if (out_valid && out_ready) k++;
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    if (k < NUM_ROWS) check("dump_timeout", k, NUM_ROWS);
    #1;
    check("done_busy", busy, 0);
    check("done_out_valid", out_valid, 0);
    check("done_out_data", out_data, 0);
  endtask

  task automatic run_job(input job_t w, input job_t e, input bit stall, input bit dww, input int mode);
    start_job();
    load_words(w, stall);
    sorter(dww);
    dump(e, mode);
  endtask

  vec_t vecs [4];
  job_t w, e;

  initial begin
    rst = 1'b1; cmd_go = 0; in_valid = 0; in_data = '0; out_ready = 0;
    srt_done = 0; srt_rd_addr = '0; srt_wr_en = 0; srt_wr_addr = '0; srt_wr_data = '0;
    tick(); tick();
    #1;
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_srt_start", srt_start, 0);
    check("rst_out_data", out_data, 0);
    rst = 1'b0;
    tick();

    // Outside SORT the read port is gated and out_ready is ignored.
    srt_rd_addr = t_addr'(1);
    out_ready   = 1'b1;
    #1;
    check("idle_rd_zero", srt_rd_data, 0);
    tick();
    out_ready = 1'b0;
    #1;
    check("idle_out_ready_ignored", busy, 0);

    vecs[0].in_w = mk(7, 3, 9, 1);       vecs[0].exp_w = mk(1, 3, 7, 9);
    vecs[1].in_w = mk(4, 4, 0, 2);       vecs[1].exp_w = mk(0, 2, 4, 4);
    vecs[2].in_w = mk(255, 0, 128, 1);   vecs[2].exp_w = mk(0, 1, 128, 255);
    vecs[3].in_w = mk(5, 5, 5, 5);       vecs[3].exp_w = mk(5, 5, 5, 5);
    for (int i = 0; i < 4; i++)
      run_job(vecs[i].in_w, vecs[i].exp_w, i[1], i[0], i % 3);

    // Same-address read/write, out-of-range access, ignored inputs in LOAD and SORT.
    start_job();
    in_valid = 1'b1; in_data = 8'd1;
    tick();
    in_valid = 1'b0;
    srt_wr_en = 1'b1; srt_wr_addr = t_addr'(0); srt_wr_data = 8'hAA; srt_done = 1'b1; cmd_go = 1'b1;
    tick();
    srt_wr_en = 1'b0; srt_done = 1'b0; cmd_go = 1'b0;
    #1;
    check("load_ignores_sorter", in_ready, 1);
    check("load_no_start", srt_start, 0);
    w = mk(1, 2, 5, 3);
    for (int r = 1; r < NUM_ROWS; r++) begin
      in_valid = 1'b1; in_data = w[r];
      tick();
    end
    in_valid = 1'b0;
    #1;
    check("manual_kick", srt_start, 1);
    tick();
    srt_rd_addr = t_addr'(0);
    #1;
    check("row0_untouched", srt_rd_data, 1);
    srt_rd_addr = t_addr'(2);
    srt_wr_en = 1'b1; srt_wr_addr = t_addr'(2); srt_wr_data = 8'd8;
    #1;
    check("raw_old_value", srt_rd_data, 5);
    tick();
    srt_wr_en = 1'b0;
    #1;
    check("raw_new_value", srt_rd_data, 8);
    srt_wr_en = 1'b1; srt_wr_addr = t_addr'(4); srt_wr_data = 8'd77;
    tick();
    srt_wr_en = 1'b0;
    e = mk(1, 2, 8, 3);
    for (int r = 0; r < NUM_ROWS; r++) begin
      srt_rd_addr = t_addr'(r);
      #1;
      check("oob_write_dropped", srt_rd_data, e[r]);
    end
    srt_rd_addr = t_addr'(4);
    #1;
    check("oob_read_zero", srt_rd_data, 0);
    cmd_go = 1'b1; in_valid = 1'b1; in_data = 8'd99; out_ready = 1'b1;
    tick();
    cmd_go = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("sort_ignore_busy", busy, 1);
    check("sort_ignore_in_ready", in_ready, 0);
    check("sort_ignore_out_valid", out_valid, 0);
    check("sort_ignore_start", srt_start, 0);
    srt_done = 1'b1;
    tick();
    srt_done = 1'b0;
    dump(e, 0);

    // Reset in the middle of a dump, then a fresh job.
    start_job();
    load_words(mk(9, 8, 7, 6), 1'b0);
    sorter(1'b0);
    out_ready = 1'b1;
    #1;
    check("pre_rst_word0", out_data, 6);
    tick();
    #1;
    check("pre_rst_word1", out_data, 7);
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_last", out_last, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_data", out_data, 0);
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    run_job(mk(4, 4, 0, 2), mk(0, 2, 4, 4), 1'b0, 1'b0, 0);

    // Reset during LOAD must restart the next load at row 0.
    start_job();
    in_valid = 1'b1; in_data = 8'd200;
    tick(); tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    w = mk(30, 10, 40, 20);
    run_job(w, ref_sort(w), 1'b1, 1'b1, 2);

    for (int n = 0; n < 8; n++) begin
      for (int r = 0; r < NUM_ROWS; r++) w[r] = t_data'($urandom);
      run_job(w, ref_sort(w), n[0], n[1], 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
